// File: rtl/prog_loader.sv
// Purpose : UART (8N1) program loader; parses A5/len/data/checksum frames and writes data bytes to program memory.
// Latency : mem_we 1 clk after the receiver emits a byte; done/err 1 clk after the checksum byte.
// Backpress: none; serial input cannot be stalled, and every write strobe is a single cycle.
// Ports   : clk, rst (sync, active-high), rx (async serial in) -> mem_we/mem_addr/mem_din (memory write port),
//           cpu_hold (CPU reset request while loading), done/err (result pulses), busy (frame FSM not idle).
module prog_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         TIMEOUT_CLKS = 5000000,
    parameter logic [9:0] BASE_ADDR    = 10'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       mem_we,
    output logic [9:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       cpu_hold,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] TMO_M1  = 32'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]  SYNC    = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;     // previous synchronized value, for falling-edge detection
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        byte_valid;
    logic        frame_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    // Edge rather than level: after a bad stop bit the line may
                    // still be low and must not be taken as a new start bit.
                    if (!rx_sync && rx_prev) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};   // LSB arrives first
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt <= '0;
                        if (rx_sync) byte_valid  <= 1'b1;
                        else         frame_error <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} fr_state_t;

    fr_state_t   fr_state;
    logic [8:0]  frame_len;   // 1..256; a length byte of 0 means 256
    logic [8:0]  idx;
    logic [7:0]  sum;
    logic [31:0] tmo_cnt;
    logic        hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_state  <= IDLE;
            frame_len <= '0;
            idx       <= '0;
            sum       <= '0;
            tmo_cnt   <= '0;
            hold      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (fr_state == IDLE) begin
                // Keeping the timer at zero here covers the reset on entry to LEN.
                tmo_cnt <= '0;
                if (byte_valid && shift == SYNC) begin
                    fr_state <= LEN;
                    hold     <= 1'b1;
                end
            end else if (frame_error || (!byte_valid && tmo_cnt == TMO_M1)) begin
                err      <= 1'b1;
                hold     <= 1'b0;
                tmo_cnt  <= '0;
                fr_state <= IDLE;
            end else if (byte_valid) begin
                tmo_cnt <= '0;
                case (fr_state)
                    LEN: begin
                        frame_len <= (shift == 8'h00) ? 9'd256 : {1'b0, shift};
                        sum       <= '0;
                        idx       <= '0;
                        fr_state  <= DATA;
                    end
                    DATA: begin
                        mem_we   <= 1'b1;
                        mem_addr <= BASE_ADDR + 10'(idx);
                        mem_din  <= shift;
                        sum      <= sum + shift;
                        idx      <= idx + 9'd1;
                        if (idx + 9'd1 == frame_len) fr_state <= CSUM;
                    end
                    CSUM: begin
                        if (shift == sum) done <= 1'b1;
                        else              err  <= 1'b1;
                        hold     <= 1'b0;
                        fr_state <= IDLE;
                    end
                    default: fr_state <= IDLE;
                endcase
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end

    // One flop drives both so they can never disagree.
    assign cpu_hold = hold;
    assign busy     = hold;

endmodule
